// File: rtl/dwpw_conv_engine.sv
// dwpw_conv_engine: fused depthwise+pointwise conv, one tap per cycle, bias/BN/ReLU6 requant,
// eight 4-bit results packed per output word.
module dwpw_conv_engine #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int IN_CH  = 64,
  parameter int OUT_CH = 128,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int ACT_W  = 4,
  parameter int OUT_AW = 10
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_act_rd_en,
  output logic [31:0]                 o_act_rd_addr,
  input  logic [ACT_W-1:0]            i_act_rd_data,
  output logic [15:0]                 o_wt_rd_addr,
  input  logic signed [7:0]           i_wt_rd_data,
  output logic [$clog2(OUT_CH)-1:0]   o_filter_idx,
  input  logic signed [7:0]           i_bias_data,
  input  logic signed [7:0]           i_scale_data,
  input  logic signed [7:0]           i_shift_data,
  output logic                        o_out_wr_en,
  output logic [OUT_AW-1:0]           o_out_wr_addr,
  output logic [31:0]                 o_out_wr_data
);
  localparam int FW      = $clog2(OUT_CH);
  localparam int OUT_W   = IMG_W + 2*PAD - K + 1;
  localparam int OUT_H   = IMG_H + 2*PAD - K + 1;
  localparam int OUT_PIX = OUT_W * OUT_H;
  localparam int WPF     = (OUT_PIX + 7) / 8;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_POST1, S_POST2, S_POST3, S_FINISH} state_t;
  state_t r_state, w_next;

  logic [15:0]        r_ch, r_ky, r_kx, r_ox, r_oy, r_pix;
  logic [FW-1:0]      r_filter;
  logic               r_busy, r_done, r_vld, r_wr_en;
  logic [OUT_AW-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data, r_pack, w_pack;
  logic signed [31:0] r_acc, w_sum, w_p2;
  logic signed [7:0]  r_t, r_b;
  logic signed [16:0] w_prod;
  logic [17:0]        w_ty, w_tx;
  logic [8:0]         w_u, w_q;
  logic [3:0]         w_r;
  logic [2:0]         w_slot;
  logic               w_inb, w_last_tap, w_last_pix, w_last_f, w_run;

  function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
    return (v > 32'sd127) ? 8'h7f : (v < -32'sd128) ? 8'h80 : v[7:0];
  endfunction

  assign w_run      = r_state == S_RUN;
  assign w_last_tap = r_ch == 16'(IN_CH-1) && r_ky == 16'(K-1) && r_kx == 16'(K-1);
  assign w_last_pix = r_pix == 16'(OUT_PIX-1);
  assign w_last_f   = r_filter == FW'(OUT_CH-1);
  // Negative coordinates wrap to huge unsigned values, so one compare covers both borders.
  assign w_ty       = 18'(r_oy) + 18'(r_ky) - 18'(PAD);
  assign w_tx       = 18'(r_ox) + 18'(r_kx) - 18'(PAD);
  assign w_inb      = w_ty < 18'(IMG_H) && w_tx < 18'(IMG_W);

  assign o_act_rd_en   = w_run && w_inb;
  assign o_act_rd_addr = o_act_rd_en ? 32'(r_ch)*32'(IMG_W*IMG_H) + 32'(w_ty)*32'(IMG_W) + 32'(w_tx) : '0;
  assign o_wt_rd_addr  = w_run ? 16'((32'(r_filter)*32'(IN_CH) + 32'(r_ch))*32'(K*K) + 32'(r_ky)*32'(K) + 32'(r_kx)) : '0;
  assign o_filter_idx  = r_filter;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_out_wr_en   = r_wr_en;
  assign o_out_wr_addr = r_wr_addr;
  assign o_out_wr_data = r_wr_data;

  assign w_prod = 17'($signed({1'b0, i_act_rd_data})) * 17'(i_wt_rd_data);
  assign w_sum  = r_acc + 32'(i_bias_data);
  assign w_p2   = 32'(r_t) * 32'(i_scale_data) + 32'(i_shift_data);
  assign w_u    = 9'(r_b) + 9'd128;
  assign w_q    = w_u / 9'd21;
  assign w_r    = w_q > 9'd6 ? 4'd6 : w_q[3:0];
  assign w_slot = r_pix[2:0];

  always_comb begin
    w_pack = r_pack;
    w_pack[{~w_slot, 2'b11} -: 4] = w_r;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:    w_next = w_last_tap ? S_DRAIN : S_RUN;
      S_DRAIN:  w_next = S_POST1;
      S_POST1:  w_next = S_POST2;
      S_POST2:  w_next = S_POST3;
      S_POST3:  w_next = (w_last_pix && w_last_f) ? S_FINISH : S_RUN;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      {r_ch, r_ky, r_kx, r_ox, r_oy, r_pix} <= '0;
      r_filter  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vld     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_pack    <= '0;
      r_acc     <= '0;
      r_t       <= '0;
      r_b       <= '0;
    end else begin
      r_vld   <= w_run && w_inb;
      r_done  <= r_state == S_FINISH;
      r_wr_en <= 1'b0;
      if (r_vld) r_acc <= r_acc + 32'(w_prod);
      if (r_state == S_IDLE && i_start) begin
        r_busy <= 1'b1;
        r_filter <= '0;
        {r_ch, r_ky, r_kx, r_ox, r_oy, r_pix} <= '0;
        r_acc  <= '0;
        r_pack <= '0;
      end
      if (w_run) begin
        if (r_kx == 16'(K-1)) begin
          r_kx <= '0;
          if (r_ky == 16'(K-1)) begin
            r_ky <= '0;
            r_ch <= w_last_tap ? '0 : r_ch + 16'd1;
          end else r_ky <= r_ky + 16'd1;
        end else r_kx <= r_kx + 16'd1;
      end
      if (r_state == S_POST1) r_t <= sat8(w_sum >>> 4);
      if (r_state == S_POST2) r_b <= sat8(w_p2 >>> 6);
      if (r_state == S_POST3) begin
        r_acc <= '0;
        if (w_slot == 3'd7 || w_last_pix) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= OUT_AW'(32'(r_filter)*32'(WPF) + 32'(r_pix >> 3));
          r_wr_data <= w_pack;
          r_pack    <= '0;
        end else r_pack <= w_pack;
        if (w_last_pix) begin
          {r_pix, r_ox, r_oy} <= '0;
          r_filter <= w_last_f ? '0 : r_filter + FW'(1);
        end else begin
          r_pix <= r_pix + 16'd1;
          r_ox  <= (r_ox == 16'(OUT_W-1)) ? '0 : r_ox + 16'd1;
          r_oy  <= (r_ox == 16'(OUT_W-1)) ? r_oy + 16'd1 : r_oy;
        end
      end
      if (r_state == S_FINISH) r_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dwpw_conv_engine.sv
// tb_dwpw_conv_engine: three engine configs (4x4 pad1, 3x3 pad1, 4x4 pad0) against an arithmetic reference model.
module tb_dwpw_conv_engine;
  localparam int IC = 2, OC = 2;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic              start [3], busy [3], done [3], are [3], wen [3], fidx [3];
  logic [31:0]       aaddr [3], wdata [3];
  logic [15:0]       waddr [3];
  logic [9:0]        wadr [3];
  logic [3:0]        ard [3];
  logic signed [7:0] wrd [3], bs [3], sc [3], sh [3];
  logic [3:0]        act_m [3][32];
  logic signed [7:0] wt_m [36], bias_m [2], scale_m [2], shift_m [2];
  logic [31:0]       cap [3][8];
  int                wcnt [3], dcnt [3], acnt [3];
  int                n_chk = 0, n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dwpw_conv_engine #(.IMG_W(g == 1 ? 3 : 4), .IMG_H(g == 1 ? 3 : 4), .IN_CH(IC), .OUT_CH(OC),
                       .K(3), .PAD(g == 2 ? 0 : 1), .ACT_W(4), .OUT_AW(10)) u_dut (
      .i_clk(clk), .i_resetn(rstn), .i_start(start[g]), .o_busy(busy[g]), .o_done(done[g]),
      .o_act_rd_en(are[g]), .o_act_rd_addr(aaddr[g]), .i_act_rd_data(ard[g]),
      .o_wt_rd_addr(waddr[g]), .i_wt_rd_data(wrd[g]), .o_filter_idx(fidx[g]),
      .i_bias_data(bs[g]), .i_scale_data(sc[g]), .i_shift_data(sh[g]),
      .o_out_wr_en(wen[g]), .o_out_wr_addr(wadr[g]), .o_out_wr_data(wdata[g]));
  end

  always_comb
    for (int i = 0; i < 3; i++) begin
      bs[i] = bias_m[fidx[i]];
      sc[i] = scale_m[fidx[i]];
      sh[i] = shift_m[fidx[i]];
    end

  initial for (int i = 0; i < 3; i++) begin wcnt[i] = 0; dcnt[i] = 0; acnt[i] = 0; end

  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (are[i]) ard[i] <= act_m[i][aaddr[i][4:0]];
      wrd[i] <= wt_m[waddr[i] < 16'd36 ? waddr[i][5:0] : 6'd0];
      if (wen[i]) begin
        cap[i][wadr[i][2:0]] <= wdata[i];
        wcnt[i] <= wcnt[i] + 1;
      end
    end

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (done[i]) dcnt[i] <= dcnt[i] + 1;
      if (are[i]) acnt[i] <= acnt[i] + 1;
    end

  function automatic int img(int c); return c == 1 ? 3 : 4; endfunction
  function automatic int padf(int c); return c == 2 ? 0 : 1; endfunction
  function automatic int outw(int c); return img(c) + 2*padf(c) - 2; endfunction
  function automatic int wpf(int c); return (outw(c)*outw(c) + 7) / 8; endfunction
  function automatic int sat8(int v); return v > 127 ? 127 : (v < -128 ? -128 : v); endfunction

  function automatic int ref_pix(int c, int f, int oy, int ox);
    int w = img(c), p = padf(c), acc = 0, t, b, r;
    for (int ch = 0; ch < IC; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          int y = oy + ky - p, x = ox + kx - p;
          if (y >= 0 && y < w && x >= 0 && x < w)
            acc += int'(act_m[c][ch*w*w + y*w + x]) * int'(wt_m[(f*IC + ch)*9 + ky*3 + kx]);
        end
    t = sat8((acc + int'(bias_m[f])) >>> 4);
    b = sat8((t * int'(scale_m[f]) + int'(shift_m[f])) >>> 6);
    r = (b + 128) / 21;
    return r > 6 ? 6 : r;
  endfunction

  function automatic logic [31:0] ref_word(int c, int f, int wi);
    logic [31:0] r = '0;
    int ow = outw(c);
    for (int s = 0; s < 8; s++) begin
      int n = wi*8 + s;
      if (n < ow*ow) r[31-4*s -: 4] = 4'(ref_pix(c, f, n / ow, n % ow));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill(input int mode);
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 32; a++) act_m[c][a] = mode == 2 ? 4'($urandom_range(15)) : 4'd15;
    for (int a = 0; a < 36; a++) wt_m[a] = mode == 2 ? 8'($urandom_range(16) - 8) : (mode == 1 ? 8'sd127 : -8'sd8);
    for (int f = 0; f < 2; f++) begin
      bias_m[f]  = mode == 2 ? 8'($urandom_range(255)) : 8'd0;
      scale_m[f] = mode == 2 ? 8'($urandom_range(255)) : (mode == 1 ? 8'sd127 : 8'sd64);
      shift_m[f] = mode == 2 ? 8'($urandom_range(255)) : 8'd0;
    end
  endtask

  task automatic run(input int c, input int restart_at, output int lat);
    @(negedge clk) start[c] = 1'b1;
    @(negedge clk) start[c] = 1'b0;
    lat = 1;
    while (!done[c] && lat < 3000) begin
      @(negedge clk);
      lat++;
      start[c] = (lat == restart_at);
    end
    start[c] = 1'b0;
    chk($sformatf("done_seen c%0d", c), 32'(done[c]), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all(input int c);
    for (int f = 0; f < OC; f++)
      for (int wi = 0; wi < wpf(c); wi++)
        chk($sformatf("word c%0d f%0d w%0d", c, f, wi), cap[c][f*wpf(c) + wi], ref_word(c, f, wi));
  endtask

  initial begin
    int lat, d0, w0, a0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy[0]), 0);
    chk("rst done", 32'(done[0]), 0);
    chk("rst act_en", 32'(are[0]), 0);
    chk("rst wr_en", 32'(wen[0]), 0);
    chk("rst wr_addr", 32'(wadr[0]), 0);
    chk("rst wr_data", wdata[0], 0);
    chk("rst filter", 32'(fidx[0]), 0);
    rstn = 1'b1;
    // 4x4 pad1: directed values, plus a second start while busy that must be ignored
    d0 = dcnt[0]; w0 = wcnt[0];
    run(0, 50, lat);
    chk("latency 4x4", lat, 706);
    chk("done once", dcnt[0] - d0, 1);
    chk("writes 4x4", wcnt[0] - w0, 4);
    chk("busy low", 32'(busy[0]), 0);
    chk("f0 w0", cap[0][0], 32'h31131001);
    chk("f0 w1", cap[0][1], 32'h10013113);
    chk("f1 w0", cap[0][2], 32'h31131001);
    chk("f1 w1", cap[0][3], 32'h10013113);
    check_all(0);
    // 3x3 pad1: ninth pixel lands alone in the second word
    w0 = wcnt[1];
    run(1, 0, lat);
    chk("latency 3x3", lat, 398);
    chk("writes 3x3", wcnt[1] - w0, 4);
    chk("3x3 f0 w1", cap[1][1], 32'h30000000);
    chk("3x3 f1 w1", cap[1][3], 32'h30000000);
    check_all(1);
    // 4x4 pad0: every tap in bounds
    w0 = wcnt[2]; a0 = acnt[2];
    run(2, 0, lat);
    chk("latency pad0", lat, 178);
    chk("act reads pad0", acnt[2] - a0, 144);
    chk("writes pad0", wcnt[2] - w0, 2);
    chk("pad0 low nibbles", {16'd0, cap[2][0][15:0]}, 0);
    check_all(2);
    // async reset in the middle of a run
    fill(1);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid busy", 32'(busy[0]), 1);
    rstn = 1'b0;
    #1;
    chk("abort busy", 32'(busy[0]), 0);
    chk("abort act_en", 32'(are[0]), 0);
    chk("abort act_addr", aaddr[0], 0);
    chk("abort wt_addr", 32'(waddr[0]), 0);
    chk("abort filter", 32'(fidx[0]), 0);
    chk("abort wr_data", wdata[0], 0);
    w0 = wcnt[0];
    @(negedge clk) rstn = 1'b1;
    repeat (60) @(negedge clk);
    chk("no writes after abort", wcnt[0] - w0, 0);
    chk("idle after abort", 32'(busy[0]), 0);
    run(0, 0, lat);
    chk("latency restart", lat, 706);
    for (int a = 0; a < 4; a++) chk($sformatf("sat w%0d", a), cap[0][a], 32'h66666666);
    // randomized data on all configs
    for (int it = 0; it < 3; it++) begin
      fill(2);
      for (int c = 0; c < 3; c++) begin
        run(c, 0, lat);
        check_all(c);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dwpw_conv_engine.md
Name: dwpw_conv_engine

Overview:
- Parametrised fused depthwise+pointwise convolution engine for the CNN datapath.
- Reads ACT_W-bit unsigned activations from the pooling buffer and signed 8-bit weights from ROM. Supports a configurable KxK window with optional zero padding.
- Applies bias/shift, BatchNorm scale and ReLU6 quantisation per output.
- Packs eight 4-bit results per 32-bit word into the conv output RAM; one tap per cycle.

Parameters:
IMG_W, 8, input/output feature map width
IMG_H, 8, input/output feature map height
IN_CH, 64, input channels accumulated per output
OUT_CH, 128, filters (output channels)
K, 3, kernel side (odd, 1..7)
PAD, 1, zero-padding border width (0 or (K-1)/2)
ACT_W, 4, activation width (unsigned)
OUT_AW, 10, output RAM word address width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  start pulse; sampled only in IDLE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at completion
act_rd_en  out  1  activation read strobe
act_rd_addr  out  32  ch*IMG_W*IMG_H + y*IMG_W + x
act_rd_data  in  ACT_W  data valid 1 cycle after act_rd_en
wt_rd_addr  out  16  (f*IN_CH+ch)*K*K+tap
wt_rd_data  in  8 signed  valid 1 cycle after address
filter_idx  out  clog2(OUT_CH)  current filter; selects bias/scale/shift
bias_data, scale_data, shift_data  in  8 signed each  per-filter constants, stable while filter_idx stable
out_wr_en  out  1  output RAM write strobe
out_wr_addr  out  OUT_AW  word address
out_wr_data  out  32  packed nibbles, pixel n%8 at bits [31-4*(n%8) -: 4]

Behaviour:
- Reset (async): all outputs 0, state IDLE, accumulator, pack register and counters cleared. Reset mid-run aborts; no further writes; start is required again.
- OUT_W = IMG_W+2*PAD-K+1, OUT_H likewise, OUT_PIX = OUT_W*OUT_H, WPF = ceil(OUT_PIX/8).
- FSM states: IDLE -> RUN -> DRAIN -> POST1 -> POST2 -> POST3 -> (RUN | FINISH) -> IDLE.
- IDLE: on start, busy<=1, filter=0, pixel=0; go to RUN. Start while busy is ignored.
- RUN: issues one tap per cycle, IN_CH*K*K cycles, in order ch outer, tap (ky,kx) inner.
  - Tap coordinate: (oy+ky-PAD, ox+kx-PAD).
  - Out-of-bounds tap: act_rd_en=0, and the tap contributes 0 one cycle later. The cycle count does not change.
  - Returned data: acc += act * w, with act zero-extended, the product signed 17-bit, acc signed 32-bit.
- DRAIN: accumulates the final returned tap.
- POST1: t = sat8((acc + bias) >>> 4).
- POST2: b = sat8((t*scale + shift) >>> 6).
- POST3: r = min((b+128)/21, 6), where b+128 is an unsigned 9-bit integer division. r is placed into slot pixel%8.
- Write rule: the cycle after POST3, out_wr_en pulses if slot==7 or the pixel is the last of the filter.
  - out_wr_addr = filter*WPF + pixel/8.
  - Unfilled slots are 0. The pack register clears after each write.
- Progress: acc clears, pixel++. At OUT_PIX, pixel=0 and filter_idx++. After the last filter, go to FINISH.
- FINISH: done=1 for one cycle, busy<=0, return to IDLE.
- Latency from the cycle start is sampled to the done pulse: OUT_CH*OUT_PIX*(IN_CH*K*K+4)+2 cycles.
- sat8 clamps to [-128,127]. All shifts are arithmetic.

Test Plan:
1. Reset during RUN (config IMG 4x4, IN_CH=2, OUT_CH=2, K=3, PAD=1) -> all outputs 0 immediately, no out_wr_en afterwards; a new start completes normally.
2. Same config, all acts=15, weights=-8, bias=0, scale=64, shift=0:
   - Corner pixels give 3, edge pixels 1, interior pixels 0.
   - Filter 0 writes addr0=0x31131001 and addr1=0x10013113.
   - Filter 1 writes the same data to addr2 and addr3.
3. acts=15, weights=127, bias=0, scale=127, shift=0 -> t=127, b saturates to 127, r clipped to 6; every word is 0x66666666.
4. IMG 3x3, PAD=1, OUT_CH=2, same data as scenario 2 -> WPF=2.
   - Per filter, 8 pixels go to the first word and pixel 8 (corner=3) to the second: addr1=0x30000000, addr3=0x30000000.
5. Assert start again while busy, mid-run -> ignored; done pulses once, exactly 2*16*(18+4)+2=706 cycles after the original start.
6. PAD=0, IMG 4x4, K=3 -> OUT_PIX=4, act_rd_en never deasserted during RUN, exactly one write per filter with the low four nibbles 0.
